// File: rtl/multi_bank_buffer_pkg.sv
// Shared definitions for multi_bank_buffer: counter width, reset bank
// indices and a constant ceil-log2 helper used to size bank indices.
package multi_bank_buffer_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int W_RST_IDX  = 0;

    // Smallest number of bits able to index 'value' distinct items.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // The reader starts on the highest bank so it never collides with the writer.
    function automatic int r_rst_idx(input int num_banks);
        return num_banks - 1;
    endfunction

endpackage

// File: rtl/multi_bank_buffer_bank_allocator.sv
// bank_allocator: owns the write/read/latest bank pointers, the "latest valid"
// flag and the superseded-bank counter. The counter exists only when
// MULTI_BANK_BUFFER_DROP_CNT_EN is defined; otherwise drop_count reads zero.
module bank_allocator
    import multi_bank_buffer_pkg::*;
#(
    parameter int NUM_BANKS = 3,
    parameter int BANK_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit,
    input  logic                  acquire,
    output logic [BANK_BITS-1:0]  write_bank,
    output logic [BANK_BITS-1:0]  read_bank,
    output logic                  fresh_avail,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic [BANK_BITS-1:0] w_r, r_r, l_r;
    logic                 lv_r;
    logic [BANK_BITS-1:0] w_s, r_s, l_s, free_s;
    logic                 lv_s, found_s;

    // Lowest bank index held by neither the writer nor the reader.
    always_comb begin
        free_s  = {BANK_BITS{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!found_s && (BANK_BITS'(i) != w_r) && (BANK_BITS'(i) != r_r)) begin
                free_s  = BANK_BITS'(i);
                found_s = 1'b1;
            end else begin
                free_s  = free_s;
            end
        end
    end

    // Pointer next-state; a simultaneous commit+acquire hands the just-finished bank straight to the reader.
    always_comb begin
        w_s  = w_r;
        r_s  = r_r;
        l_s  = l_r;
        lv_s = lv_r;
        case ({commit, acquire})
            2'b11: begin
                r_s  = w_r;
                w_s  = free_s;
                lv_s = 1'b0;
            end
            2'b10: begin
                l_s  = w_r;
                lv_s = 1'b1;
                w_s  = free_s;
            end
            2'b01: begin
                if (lv_r) begin
                    r_s  = l_r;
                    lv_s = 1'b0;
                end else begin
                    r_s  = r_r;
                end
            end
            default: begin
                lv_s = lv_r;
            end
        endcase
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_r  <= BANK_BITS'(W_RST_IDX);
            r_r  <= BANK_BITS'(r_rst_idx(NUM_BANKS));
            l_r  <= {BANK_BITS{1'b0}};
            lv_r <= 1'b0;
        end else begin
            w_r  <= w_s;
            r_r  <= r_s;
            l_r  <= l_s;
            lv_r <= lv_s;
        end
    end

    assign write_bank  = w_r;
    assign read_bank   = r_r;
    assign fresh_avail = lv_r;

`ifdef MULTI_BANK_BUFFER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_r;
    logic                  drop_s;

    // A commit while an unread bank is pending discards that bank.
    assign drop_s = commit & lv_r;

    // Saturating count of discarded banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= {DROP_CNT_W{1'b0}};
        end else if (drop_s && (drop_r != {DROP_CNT_W{1'b1}})) begin
            drop_r <= drop_r + 16'd1;
        end
    end

    assign drop_count = drop_r;
`else
    assign drop_count = {DROP_CNT_W{1'b0}};
`endif

endmodule

// File: rtl/multi_bank_buffer.sv
// multi_bank_buffer: N-bank latest-wins frame buffer. One writer fills a bank
// and commits it; the reader acquires the newest committed bank. Optional drop
// counter enabled by MULTI_BANK_BUFFER_DROP_CNT_EN.
module multi_bank_buffer
    import multi_bank_buffer_pkg::*;
#(
    parameter  int RAM_WIDTH     = 36,
    parameter  int RAM_ADDR_BITS = 11,
    parameter  int NUM_BANKS     = 3,
    localparam int BANK_BITS     = clog2(NUM_BANKS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_enable,
    input  logic [RAM_ADDR_BITS-1:0] write_addr,
    input  logic [RAM_WIDTH-1:0]     write_data,
    input  logic                     write_commit,
    input  logic                     read_acquire,
    input  logic                     read_en,
    input  logic [RAM_ADDR_BITS-1:0] read_addr,
    output logic [RAM_WIDTH-1:0]     read_data,
    output logic                     read_valid,
    output logic [BANK_BITS-1:0]     write_bank,
    output logic [BANK_BITS-1:0]     read_bank,
    output logic                     fresh_avail,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    localparam int AW    = BANK_BITS + RAM_ADDR_BITS;
    localparam int DEPTH = 1 << AW;

    logic [RAM_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_addr_s, rd_addr_s;

    bank_allocator #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_BITS (BANK_BITS)
    ) u_alloc (
        .clk         (clk),
        .rst         (rst),
        .commit      (write_commit),
        .acquire     (read_acquire),
        .write_bank  (write_bank),
        .read_bank   (read_bank),
        .fresh_avail (fresh_avail),
        .drop_count  (drop_count)
    );

    // Accesses in a pulse cycle still use the pre-pulse bank indices.
    assign wr_addr_s = {write_bank, write_addr};
    assign rd_addr_s = {read_bank, read_addr};

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem_r[wr_addr_s] <= write_data;
        end
    end

    // Storage read port, one cycle latency.
    always_ff @(posedge clk) begin
        if (read_en) begin
            read_data <= mem_r[rd_addr_s];
        end
    end

    // read_valid tracks read_en one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_en;
        end
    end

endmodule

// File: tb/tb_multi_bank_buffer.sv
// Self-checking bench for multi_bank_buffer: directed scenarios followed by
// random traffic, compared against a bank-ownership model with a sparse memory.
module tb_multi_bank_buffer;

    localparam int NB = 3;
    localparam int AB = 11;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_enable, write_commit, read_acquire, read_en;
    logic [AB-1:0] write_addr, read_addr;
    logic [DW-1:0] write_data, read_data;
    logic          read_valid, fresh_avail;
    logic [1:0]    write_bank, read_bank;
    logic [15:0]   drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int            w_m, r_m, l_m, drops_m;
    bit            lv_m;
    logic [DW-1:0] mem_m [int];

    multi_bank_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_commit (write_commit),
        .read_acquire (read_acquire),
        .read_en      (read_en),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .write_bank   (write_bank),
        .read_bank    (read_bank),
        .fresh_avail  (fresh_avail),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef MULTI_BANK_BUFFER_DROP_CNT_EN
        return drops_m;
`else
        return 0;
`endif
    endfunction

    function automatic int lowest_free(input int a, input int b);
        for (int i = 0; i < NB; i++) begin
            if (i != a && i != b) return i;
        end
        return -1;
    endfunction

    function automatic int key(input int bank, input int addr);
        return bank * (1 << AB) + addr;
    endfunction

    task automatic model_reset();
        w_m = 0; r_m = NB - 1; l_m = 0; lv_m = 1'b0; drops_m = 0;
    endtask

    task automatic check_ptrs(input string tag);
        check({tag, "_wbank"}, 64'(write_bank), 64'(w_m));
        check({tag, "_rbank"}, 64'(read_bank), 64'(r_m));
        check({tag, "_fresh"}, 64'(fresh_avail), 64'(lv_m));
        check({tag, "_drop"},  64'(drop_count), 64'(exp_drop()));
    endtask

    // One clock cycle of stimulus, then model update and output checks.
    task automatic step(input string tag, input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit cm, input bit aq, input bit re, input int ra);
        bit            known;
        logic [DW-1:0] exp_rd;
        int            nw;
        write_enable = we; write_addr = wa[AB-1:0]; write_data = wd;
        write_commit = cm; read_acquire = aq;
        read_en = re; read_addr = ra[AB-1:0];
        known  = re && mem_m.exists(key(r_m, ra));
        exp_rd = known ? mem_m[key(r_m, ra)] : '0;
        @(posedge clk);
        #1;
        if (we) mem_m[key(w_m, wa)] = wd;
        if (cm) begin
            if (lv_m && drops_m < 65535) drops_m++;
            nw = lowest_free(w_m, r_m);
            if (aq) begin
                r_m = w_m;
                lv_m = 1'b0;
            end else begin
                l_m = w_m;
                lv_m = 1'b1;
            end
            w_m = nw;
        end else if (aq && lv_m) begin
            r_m = l_m;
            lv_m = 1'b0;
        end
        write_enable = 1'b0; write_commit = 1'b0; read_acquire = 1'b0; read_en = 1'b0;
        check({tag, "_rvalid"}, 64'(read_valid), 64'(re));
        if (known) check({tag, "_rdata"}, 64'(read_data), 64'(exp_rd));
        check_ptrs(tag);
    endtask

    // Writer and reader banks must never coincide.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_checks++;
            assert (write_bank !== read_bank) else begin
                n_fail++;
                $error("FAIL bank_overlap: observed w=%0d r=%0d expected distinct", write_bank, read_bank);
            end
        end
    end

    initial begin
        rst = 1'b1;
        write_enable = 1'b0; write_commit = 1'b0; read_acquire = 1'b0; read_en = 1'b0;
        write_addr = '0; read_addr = '0; write_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid", 64'(read_valid), 64'd0);
        check_ptrs("reset");
        rst = 1'b0;

        // 1: single frame round trip
        step("t1_wr",  1, 5, 36'hA5, 0, 0, 0, 0);
        step("t1_cm",  0, 0, '0,     1, 0, 0, 0);
        step("t1_aq",  0, 0, '0,     0, 1, 0, 0);
        step("t1_rd",  0, 0, '0,     0, 0, 1, 5);
        check("t1_rdata_const", 64'(read_data), 64'hA5);
        check("t1_rbank_const", 64'(read_bank), 64'd0);

        // 2: three commits without acquire, latest wins
        for (int k = 1; k <= 3; k++) begin
            step("t2_wr", 1, 7, 36'(32'h100 + k), 0, 0, 0, 0);
            step("t2_cm", 0, 0, '0, 1, 0, 0, 0);
        end
`ifdef MULTI_BANK_BUFFER_DROP_CNT_EN
        check("t2_drop_const", 64'(drop_count), 64'd2);
`else
        check("t2_drop_const", 64'(drop_count), 64'd0);
`endif
        check("t2_fresh_const", 64'(fresh_avail), 64'd1);
        step("t2_aq", 0, 0, '0, 0, 1, 0, 0);
        step("t2_rd", 0, 0, '0, 0, 0, 1, 7);
        check("t2_rdata_const", 64'(read_data), 64'h103);

        // 3: acquire with nothing fresh
        step("t3_aq", 0, 0, '0, 0, 1, 0, 0);
        check("t3_rdata_known", 64'($isunknown(read_data)), 64'd0);

        // 4: commit then commit+acquire together
        step("t4_cm",   1, 3, 36'h444, 1, 0, 0, 0);
        step("t4_cmaq", 1, 3, 36'h555, 1, 1, 0, 0);
        step("t4_rd",   0, 0, '0,      0, 0, 1, 3);
        check("t4_rdata_const", 64'(read_data), 64'h555);

        // 5: same address written and read in one cycle
        step("t5_rw", 1, 3, 36'h777, 0, 0, 1, 3);

        // 6: asynchronous reset mid-frame
        step("t6_wr", 1, 1, 36'h66, 1, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_async_rvalid", 64'(read_valid), 64'd0);
        check_ptrs("t6_async");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 36'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
